// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes understood by the ALU and the
// state encoding of the arbiter that feeds it.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set valid bit at or
// after ptr, wrapping around, and reports it one-hot and as an index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;
    int            sum;

    // Scan candidates in priority order starting at ptr; the first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        sum  = 0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IW'(sum);
            if (!any && valid[cand]) begin
                any      = 1'b1;
                gnt[cand] = 1'b1;
                idx      = cand;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between N_REQ requesters: round-robin grant,
// registered operands, captured result returned over valid/ready.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [4*N_REQ-1:0]     req_ctrl,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_zero,
    output logic [3:0]             alu_ctrl,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_zero
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state_q;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     ptr_next;
    logic [IW-1:0]     pick_idx;
    logic [N_REQ-1:0]  pick_gnt;
    logic              pick_any;
    logic [3:0]        ctrl_q;
    logic [3:0]        sel_ctrl;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [WIDTH-1:0]  res_q;
    logic              zero_q;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The grant is one-hot, so OR-ing the masked fields selects the winner.
    always_comb begin
        sel_ctrl = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_ctrl = sel_ctrl | req_ctrl[4*i +: 4];
                sel_a    = sel_a | req_a[WIDTH*i +: WIDTH];
                sel_b    = sel_b | req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = (state_q == IDLE) ? pick_gnt : '0;
    assign ptr_next  = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    assign rsp_data  = res_q;
    assign rsp_zero  = zero_q;
    assign alu_ctrl  = ctrl_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;

    // One operation in flight: accept in IDLE, sample the ALU in EXEC,
    // then hold the result until the granted requester takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        ctrl_q  <= sel_ctrl;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        gnt_idx <= pick_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= alu_out;
                    zero_q  <= alu_zero;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        rr_ptr  <= ptr_next;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_ctrl;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_zero;
    logic [3:0]     alu_ctrl;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_out;
    logic           alu_zero;

    int n_compared   = 0;
    int n_mismatched = 0;

    alu_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctrl  (req_ctrl),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .alu_ctrl  (alu_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            ALU_NOR: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_ctrl, alu_a, alu_b);
    assign alu_zero = (alu_out == '0);

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[r]       = 1'b1;
        req_ctrl[4*r +: 4] = c;
        req_a[W*r +: W]    = a;
        req_b[W*r +: W]    = b;
    endtask

    // Transaction-level model: busy flag, cycles since acceptance, pointer.
    bit           m_busy = 0;
    int           m_age  = 0;
    int           m_ptr  = 0;
    int           m_gnt  = 0;
    logic [3:0]   m_ctrl = '0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    int           m_w;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_age = 0; m_ptr = 0; m_gnt = 0;
            m_ctrl = '0; m_a = '0; m_b = '0;
        end else if (!m_busy) begin
            m_w = winner(req_valid, m_ptr);
            if (m_w >= 0) begin
                m_busy = 1; m_age = 1; m_gnt = m_w;
                m_ctrl = req_ctrl[4*m_w +: 4];
                m_a    = req_a[W*m_w +: W];
                m_b    = req_b[W*m_w +: W];
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (rsp_ready[m_gnt]) begin
            m_busy = 0;
            m_ptr  = (m_gnt + 1) % N;
        end
    end

    int           c_w;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_res;

    always @(negedge clk) begin
        if (!reset) begin
            c_w = winner(req_valid, m_ptr);
            exp_ready = '0;
            if (!m_busy && c_w >= 0) exp_ready[c_w] = 1'b1;
            exp_rv = '0;
            if (m_busy && m_age == 2) exp_rv[m_gnt] = 1'b1;
            checkOutput("cyc_req_ready", 64'(req_ready), 64'(exp_ready));
            checkOutput("cyc_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            checkOutput("cyc_alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
            checkOutput("cyc_alu_a", 64'(alu_a), 64'(m_a));
            checkOutput("cyc_alu_b", 64'(alu_b), 64'(m_b));
            if (exp_rv != '0) begin
                exp_res = alu_fn(m_ctrl, m_a, m_b);
                checkOutput("cyc_rsp_data", 64'(rsp_data), 64'(exp_res));
                checkOutput("cyc_rsp_zero", 64'(rsp_zero), 64'(exp_res == '0));
            end
        end
    end

    task automatic doOp(input int r, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_z, input string name);
        logic [N-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        @(posedge clk); #1;
        rsp_ready = '0;
        applyStimulus(r, c, a, b);
        @(negedge clk);
        checkOutput({name, "_req_ready"}, 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        checkOutput({name, "_exec_rsp_valid"}, 64'(rsp_valid), 64'(0));
        @(negedge clk);
        checkOutput({name, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
        checkOutput({name, "_rsp_data"}, 64'(rsp_data), 64'(exp_d));
        checkOutput({name, "_rsp_zero"}, 64'(rsp_zero), 64'(exp_z));
        @(posedge clk); #1;
        rsp_ready = oh;
        @(posedge clk); #1;
        rsp_ready = '0;
        @(negedge clk);
        checkOutput({name, "_back_idle"}, 64'(rsp_valid), 64'(0));
    endtask

    logic [N-1:0] gr [4];
    int           ng;
    logic         hit;
    logic [N-1:0] xfer;

    initial begin
        reset = 1'b1; req_valid = '0; req_ctrl = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", 64'(req_ready), 64'(0));
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("reset_alu_ctrl", 64'(alu_ctrl), 64'(0));
        checkOutput("reset_alu_a", 64'(alu_a), 64'(0));
        checkOutput("reset_alu_b", 64'(alu_b), 64'(0));
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'(0));
        checkOutput("reset_rsp_zero", 64'(rsp_zero), 64'(0));

        doOp(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, "single");
        doOp(1, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1, "zero");

        // Contention straight after reset: grants must alternate from 0.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        applyStimulus(0, ALU_OR, 32'hF0, 32'h0F);
        applyStimulus(1, ALU_SLT, 32'd3, 32'd7);
        rsp_ready = '1;
        ng = 0;
        for (int cyc = 0; cyc < 30 && ng < 4; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gr[ng] = req_ready;
                ng++;
            end
            if (rsp_valid == 2'b01) checkOutput("contention_data0", 64'(rsp_data), 64'hFF);
            else if (rsp_valid == 2'b10) checkOutput("contention_data1", 64'(rsp_data), 64'h1);
        end
        checkOutput("contention_count", 64'(ng), 64'(4));
        checkOutput("contention_grant0", 64'(gr[0]), 64'(2'b01));
        checkOutput("contention_grant1", 64'(gr[1]), 64'(2'b10));
        checkOutput("contention_grant2", 64'(gr[2]), 64'(2'b01));
        checkOutput("contention_grant3", 64'(gr[3]), 64'(2'b10));
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Backpressure: result held while requester 1 waits for its turn.
        #1 rsp_ready = '0;
        applyStimulus(0, ALU_AND, 32'hF0F0, 32'hFF00);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        applyStimulus(1, ALU_ADD, 32'd100, 32'd23);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
            checkOutput("bp_rsp_data", 64'(rsp_data), 64'hF000);
            checkOutput("bp_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1 rsp_ready = 2'b01;
        @(negedge clk);
        checkOutput("bp_last_valid", 64'(rsp_valid), 64'(2'b01));
        @(negedge clk);
        checkOutput("bp_release_rsp", 64'(rsp_valid), 64'(0));
        checkOutput("bp_release_ready", 64'(req_ready), 64'(2'b10));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_req1_valid", 64'(rsp_valid), 64'(2'b10));
        checkOutput("bp_req1_data", 64'(rsp_data), 64'd123);
        @(posedge clk); #1 rsp_ready = '0;

        doOp(0, 4'd15, 32'd1, 32'd1, 32'd0, 1'b1, "undef");

        // Reset while EXEC: the operation vanishes and the pointer restarts at 0.
        @(posedge clk); #1;
        applyStimulus(1, ALU_ADD, 32'd1, 32'd2);
        rsp_ready = '1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_exec_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("rst_exec_req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst_exec_alu_ctrl", 64'(alu_ctrl), 64'(0));
        checkOutput("rst_exec_alu_a", 64'(alu_a), 64'(0));
        checkOutput("rst_exec_alu_b", 64'(alu_b), 64'(0));
        checkOutput("rst_exec_rsp_data", 64'(rsp_data), 64'(0));
        checkOutput("rst_exec_rsp_zero", 64'(rsp_zero), 64'(0));
        hit = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid != '0) hit = 1'b1;
        end
        checkOutput("rst_exec_no_rsp", 64'(hit), 64'(0));
        @(posedge clk); #1;
        applyStimulus(0, ALU_NOR, 32'd0, 32'd0);
        applyStimulus(1, ALU_ADD, 32'd4, 32'd4);
        @(negedge clk);
        checkOutput("rst_exec_winner", 64'(req_ready), 64'(2'b01));
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Random traffic; requesters hold operands until granted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            xfer = req_valid & req_ready;
            @(posedge clk); #1;
            reset = ($urandom_range(0, 299) == 0);
            for (int r = 0; r < N; r++) begin
                if (req_valid[r] && !xfer[r]) begin
                    if ($urandom_range(0, 9) == 0) req_valid[r] = 1'b0;
                end else if ($urandom_range(0, 1) == 0) begin
                    case ($urandom_range(0, 7))
                        0: req_ctrl[4*r +: 4] = ALU_AND;
                        1: req_ctrl[4*r +: 4] = ALU_OR;
                        2: req_ctrl[4*r +: 4] = ALU_ADD;
                        3: req_ctrl[4*r +: 4] = ALU_SUB;
                        4: req_ctrl[4*r +: 4] = ALU_SLT;
                        5: req_ctrl[4*r +: 4] = ALU_NOR;
                        default: req_ctrl[4*r +: 4] = 4'($urandom);
                    endcase
                    if ($urandom_range(0, 3) == 0) begin
                        req_a[W*r +: W] = W'($urandom_range(0, 3));
                        req_b[W*r +: W] = W'($urandom_range(0, 3));
                    end else begin
                        req_a[W*r +: W] = W'($urandom);
                        req_b[W*r +: W] = W'($urandom);
                    end
                    req_valid[r] = 1'b1;
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
            rsp_ready = N'($urandom);
        end
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
